// File: rtl/exception_vector_unit.sv
// Exception-entry sequencer: arbitrates pending exception requests by fixed
// priority, saves the EPC, fetches the handler byte from the vector table and
// strobes the new PC back into the datapath.
module exception_vector_unit #(
  parameter int NUM_EXC     = 3,
  parameter int DATA_W      = 32,
  parameter int VECTOR_BASE = 253,
  parameter int MEM_WAIT    = 2,
  parameter int PC_OFFSET   = 4,
  localparam int CAUSE_W    = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_EXC-1:0]  exc_req,
  input  logic [DATA_W-1:0]   pc_in,
  input  logic [7:0]          mem_data_in,
  output logic [DATA_W-1:0]   mem_addr,
  output logic                mem_read,
  output logic [DATA_W-1:0]   epc_out,
  output logic [CAUSE_W-1:0]  cause_out,
  output logic [DATA_W-1:0]   pc_out,
  output logic                pc_write,
  output logic                busy
);

  localparam int CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(MEM_WAIT - 1);
  localparam logic [DATA_W-1:0] VBASE    = DATA_W'(VECTOR_BASE);
  localparam logic [DATA_W-1:0] OFFS     = DATA_W'(PC_OFFSET);

  if (NUM_EXC < 2) begin : g_bad_num_exc
    $error("exception_vector_unit: NUM_EXC must be at least 2");
  end
  if (MEM_WAIT < 1) begin : g_bad_mem_wait
    $error("exception_vector_unit: MEM_WAIT must be at least 1");
  end
  if (DATA_W < 8) begin : g_bad_data_w
    $error("exception_vector_unit: DATA_W must hold the handler byte");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t              state_q,    state_d;
  logic [NUM_EXC-1:0]  pend_q,     pend_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]   epc_q,      epc_d;
  logic [CAUSE_W-1:0]  cause_q,    cause_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_read_q, mem_read_d;
  logic                pc_write_q, pc_write_d;
  logic                busy_q,     busy_d;

  logic [NUM_EXC-1:0]  req;
  logic [NUM_EXC-1:0]  lowest_onehot;
  logic [NUM_EXC-1:0]  grant_onehot;
  logic [CAUSE_W-1:0]  grant_idx;
  logic                grant_vld;

  // Fixed priority: the lowest-index set bit wins.
  always_comb begin
    req           = pend_q | exc_req;
    lowest_onehot = req & (~req + 1'b1);
    grant_vld     = 1'b0;
    grant_idx     = '0;
    for (int i = NUM_EXC - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_vld = 1'b1;
        grant_idx = CAUSE_W'(i);
      end
    end
    grant_onehot = (state_q == S_IDLE) ? lowest_onehot : '0;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    epc_d      = epc_q;
    cause_d    = cause_q;
    pend_d     = req & ~grant_onehot;

    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          state_d    = S_READ;
          cause_d    = grant_idx;
          epc_d      = pc_in - OFFS;
          wait_cnt_d = CNT_INIT;
        end
      end
      S_READ: begin
        if (wait_cnt_q == '0) begin
          state_d = S_LOAD;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      S_LOAD: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes are registered from the next state so they align with it.
    mem_read_d = (state_d == S_READ);
    mem_addr_d = (state_d == S_READ) ? (VBASE + DATA_W'(cause_d)) : '0;
    pc_write_d = (state_d == S_LOAD);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pend_q     <= '0;
      wait_cnt_q <= '0;
      epc_q      <= '0;
      cause_q    <= '0;
      mem_addr_q <= '0;
      mem_read_q <= 1'b0;
      pc_write_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      wait_cnt_q <= wait_cnt_d;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
      mem_addr_q <= mem_addr_d;
      mem_read_q <= mem_read_d;
      pc_write_q <= pc_write_d;
      busy_q     <= busy_d;
    end
  end

  // Handler byte passes straight through during LOAD; memory holds it valid then.
  assign pc_out    = pc_write_q ? DATA_W'(mem_data_in) : '0;
  assign mem_addr  = mem_addr_q;
  assign mem_read  = mem_read_q;
  assign pc_write  = pc_write_q;
  assign busy      = busy_q;
  assign epc_out   = epc_q;
  assign cause_out = cause_q;

endmodule

// File: tb/tb_exception_vector_unit.sv
// Directed bench for exception_vector_unit with default parameters
// (NUM_EXC=3, VECTOR_BASE=253, MEM_WAIT=2, PC_OFFSET=4).
module tb_exception_vector_unit;

  logic        clk;
  logic        reset;
  logic [2:0]  exc_req;
  logic [31:0] pc_in;
  logic [7:0]  mem_data_in;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [31:0] epc_out;
  logic [1:0]  cause_out;
  logic [31:0] pc_out;
  logic        pc_write;
  logic        busy;

  int n_cmp;
  int n_fail;

  logic [66:0] obs;

  exception_vector_unit dut (
    .clk         (clk),
    .reset       (reset),
    .exc_req     (exc_req),
    .pc_in       (pc_in),
    .mem_data_in (mem_data_in),
    .mem_addr    (mem_addr),
    .mem_read    (mem_read),
    .epc_out     (epc_out),
    .cause_out   (cause_out),
    .pc_out      (pc_out),
    .pc_write    (pc_write),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {busy, mem_read, mem_addr, pc_write, pc_out};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    exc_req = 3'b000;
    pc_in = 32'h0;
    mem_data_in = 8'h0;
    step();
    step();
    n_cmp++;
    if (obs !== {1'b0, 1'b0, 32'd0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h", obs, {1'b0, 1'b0, 32'd0, 1'b0, 32'd0});
    end
    n_cmp++;
    if ({epc_out, cause_out} !== {32'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_epc_cause: got epc=%h cause=%0d want epc=0 cause=0", epc_out, cause_out);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b want 0", busy);
    end
  endtask

  task automatic test_single();
    exc_req = 3'b010;
    pc_in = 32'h100;
    mem_data_in = 8'h40;
    step();
    exc_req = 3'b000;
    n_cmp++;
    if ({cause_out, epc_out} !== {2'd1, 32'hFC}) begin
      n_fail++;
      $display("FAIL single_grant: cause=%0d epc=%h want cause=1 epc=fc", cause_out, epc_out);
    end
    n_cmp++;
    if (obs !== {1'b1, 1'b1, 32'd254, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL single_read1: got %h want %h", obs, {1'b1, 1'b1, 32'd254, 1'b0, 32'd0});
    end
    step();
    n_cmp++;
    if (obs !== {1'b1, 1'b1, 32'd254, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL single_read2: got %h want %h", obs, {1'b1, 1'b1, 32'd254, 1'b0, 32'd0});
    end
    step();
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 32'd0, 1'b1, 32'h40}) begin
      n_fail++;
      $display("FAIL single_load: got %h want %h", obs, {1'b1, 1'b0, 32'd0, 1'b1, 32'h40});
    end
    step();
    n_cmp++;
    if (obs !== {1'b0, 1'b0, 32'd0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL single_idle: got %h want %h", obs, {1'b0, 1'b0, 32'd0, 1'b0, 32'd0});
    end
    n_cmp++;
    if ({cause_out, epc_out} !== {2'd1, 32'hFC}) begin
      n_fail++;
      $display("FAIL single_hold: cause=%0d epc=%h want cause=1 epc=fc", cause_out, epc_out);
    end
  endtask

  task automatic test_simultaneous_and_busy();
    exc_req = 3'b110;
    pc_in = 32'h200;
    mem_data_in = 8'h66;
    step();
    exc_req = 3'b000;
    n_cmp++;
    if ({cause_out, epc_out, mem_addr} !== {2'd1, 32'h1FC, 32'd254}) begin
      n_fail++;
      $display("FAIL simul_first: cause=%0d epc=%h addr=%0d want 1 1fc 254", cause_out, epc_out, mem_addr);
    end
    step();
    step();
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 32'd0, 1'b1, 32'h66}) begin
      n_fail++;
      $display("FAIL simul_first_load: got %h want %h", obs, {1'b1, 1'b0, 32'd0, 1'b1, 32'h66});
    end
    step();
    n_cmp++;
    if (obs !== {1'b0, 1'b0, 32'd0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL simul_gap_idle: got %h want %h", obs, {1'b0, 1'b0, 32'd0, 1'b0, 32'd0});
    end
    step();
    n_cmp++;
    if ({cause_out, epc_out} !== {2'd2, 32'h1FC} ||
        obs !== {1'b1, 1'b1, 32'd255, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL simul_second: cause=%0d epc=%h obs=%h want cause=2 epc=1fc addr=255 read",
               cause_out, epc_out, obs);
    end
    // Pulse cause 0 while cause 2 is being serviced.
    exc_req = 3'b001;
    pc_in = 32'h300;
    step();
    exc_req = 3'b000;
    n_cmp++;
    if ({cause_out, epc_out, mem_addr, mem_read} !== {2'd2, 32'h1FC, 32'd255, 1'b1}) begin
      n_fail++;
      $display("FAIL busy_read2: cause=%0d epc=%h addr=%0d rd=%b want 2 1fc 255 1",
               cause_out, epc_out, mem_addr, mem_read);
    end
    step();
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 32'd0, 1'b1, 32'h66}) begin
      n_fail++;
      $display("FAIL busy_load: got %h want %h", obs, {1'b1, 1'b0, 32'd0, 1'b1, 32'h66});
    end
    // Re-assert the already-pending cause; it must merge, not queue twice.
    exc_req = 3'b001;
    step();
    exc_req = 3'b000;
    n_cmp++;
    if (obs !== {1'b0, 1'b0, 32'd0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL busy_gap_idle: got %h want %h", obs, {1'b0, 1'b0, 32'd0, 1'b0, 32'd0});
    end
    mem_data_in = 8'h77;
    step();
    n_cmp++;
    if ({cause_out, epc_out} !== {2'd0, 32'h2FC} ||
        obs !== {1'b1, 1'b1, 32'd253, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL pending_grant: cause=%0d epc=%h obs=%h want cause=0 epc=2fc addr=253 read",
               cause_out, epc_out, obs);
    end
    step();
    step();
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 32'd0, 1'b1, 32'h77}) begin
      n_fail++;
      $display("FAIL pending_load: got %h want %h", obs, {1'b1, 1'b0, 32'd0, 1'b1, 32'h77});
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (busy !== 1'b0 || pc_write !== 1'b0) begin
        n_fail++;
        $display("FAIL merge_no_repeat[%0d]: busy=%b pc_write=%b want 0 0", i, busy, pc_write);
      end
    end
  endtask

  task automatic test_reset_mid();
    exc_req = 3'b110;
    pc_in = 32'h400;
    step();
    exc_req = 3'b000;
    step();
    n_cmp++;
    if ({busy, mem_read, mem_addr} !== {1'b1, 1'b1, 32'd254}) begin
      n_fail++;
      $display("FAIL rstmid_read2: busy=%b rd=%b addr=%0d want 1 1 254", busy, mem_read, mem_addr);
    end
    #3;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({obs, epc_out, cause_out} !== {67'd0, 32'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL rstmid_async: obs=%h epc=%h cause=%0d want all 0", obs, epc_out, cause_out);
    end
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++;
      if (busy !== 1'b0 || pc_write !== 1'b0 || mem_read !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_quiet[%0d]: busy=%b pc_write=%b rd=%b want 0 0 0",
                 i, busy, pc_write, mem_read);
      end
    end
  endtask

  task automatic test_epc_wrap();
    exc_req = 3'b001;
    pc_in = 32'h2;
    mem_data_in = 8'h99;
    step();
    exc_req = 3'b000;
    n_cmp++;
    if ({cause_out, epc_out, mem_addr} !== {2'd0, 32'hFFFF_FFFE, 32'd253}) begin
      n_fail++;
      $display("FAIL epc_wrap: cause=%0d epc=%h addr=%0d want 0 fffffffe 253", cause_out, epc_out, mem_addr);
    end
    step();
    step();
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 32'd0, 1'b1, 32'h99}) begin
      n_fail++;
      $display("FAIL wrap_load: got %h want %h", obs, {1'b1, 1'b0, 32'd0, 1'b1, 32'h99});
    end
    step();
    n_cmp++;
    if (obs !== {1'b0, 1'b0, 32'd0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL wrap_idle: got %h want %h", obs, {1'b0, 1'b0, 32'd0, 1'b0, 32'd0});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_simultaneous_and_busy();
    test_reset_mid();
    test_epc_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
